// File: rtl/pipe_skid_latch.sv
// Valid/ready pipeline-stage latch with a 2-entry skid buffer and synchronous flush.
// Optional saturating stall counter enabled by defining PIPE_SKID_STALL_CNT_EN.
//
// state | meaning
// EMPTY | no entry held, OUT_V=0, IN_RDY=1
// ONE   | main register valid, skid unused
// FULL  | main and skid valid, IN_RDY=0
module pipe_skid_latch #(
    parameter int                 WIDTH      = 32,
    parameter logic [WIDTH-1:0]   RESET_DATA = '0,
    parameter int                 CNT_W      = 16
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             FLUSH,
    input  logic             IN_V,
    input  logic [WIDTH-1:0] IN_DATA,
    output logic             IN_RDY,
    output logic             OUT_V,
    output logic [WIDTH-1:0] OUT_DATA,
    input  logic             OUT_RDY,
`ifdef PIPE_SKID_STALL_CNT_EN
    output logic [CNT_W-1:0] STALL_CNT,
`endif
    output logic [1:0]       OCC
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   main_q, main_d;
    logic [WIDTH-1:0]   skid_q, skid_d;
    logic               out_v_q, out_v_d;
    logic               in_rdy_q, in_rdy_d;
    logic [1:0]         occ_q, occ_d;
    logic               in_fire;
    logic               out_fire;

    assign in_fire  = IN_V & in_rdy_q;
    assign out_fire = out_v_q & OUT_RDY;

    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        // Flush overrides every transition and suppresses all data loads.
        if (FLUSH) begin
            state_d = EMPTY;
        end else begin
            case (state_q)
                EMPTY: begin
                    if (in_fire) begin
                        main_d  = IN_DATA;
                        state_d = ONE;
                    end
                end
                ONE: begin
                    if (in_fire && out_fire) begin
                        main_d = IN_DATA;
                    end else if (in_fire) begin
                        skid_d  = IN_DATA;
                        state_d = FULL;
                    end else if (out_fire) begin
                        state_d = EMPTY;
                    end
                end
                FULL: begin
                    if (out_fire) begin
                        main_d  = skid_q;
                        state_d = ONE;
                    end
                end
                default: state_d = EMPTY;
            endcase
        end

        out_v_d  = (state_d != EMPTY);
        in_rdy_d = (state_d != FULL);
        case (state_d)
            ONE:     occ_d = 2'd1;
            FULL:    occ_d = 2'd2;
            default: occ_d = 2'd0;
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q  <= EMPTY;
            main_q   <= RESET_DATA;
            skid_q   <= RESET_DATA;
            out_v_q  <= 1'b0;
            in_rdy_q <= 1'b1;
            occ_q    <= 2'd0;
        end else begin
            state_q  <= state_d;
            main_q   <= main_d;
            skid_q   <= skid_d;
            out_v_q  <= out_v_d;
            in_rdy_q <= in_rdy_d;
            occ_q    <= occ_d;
        end
    end

    assign OUT_V    = out_v_q;
    assign IN_RDY   = in_rdy_q;
    assign OUT_DATA = main_q;
    assign OCC      = occ_q;

`ifdef PIPE_SKID_STALL_CNT_EN
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (out_v_q && !OUT_RDY && (stall_cnt_q != {CNT_W{1'b1}})) begin
            stall_cnt_d = stall_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            stall_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign STALL_CNT = stall_cnt_q;
`endif

endmodule

// File: tb/tb_pipe_skid_latch.sv
// Directed self-checking bench for pipe_skid_latch (WIDTH=32, RESET_DATA=0).
// The stall counter scenario is built only when PIPE_SKID_STALL_CNT_EN is defined.
module tb_pipe_skid_latch;

    localparam int WIDTH = 32;
    localparam int CNT_W = 2;

    logic             clk;
    logic             rst;
    logic             flush;
    logic             in_v;
    logic [WIDTH-1:0] in_data;
    logic             in_rdy;
    logic             out_v;
    logic [WIDTH-1:0] out_data;
    logic             out_rdy;
    logic [1:0]       occ;
`ifdef PIPE_SKID_STALL_CNT_EN
    logic [CNT_W-1:0] stall_cnt;
`endif

    int n_checks;
    int n_fail;

    pipe_skid_latch #(
        .WIDTH      (WIDTH),
        .RESET_DATA ('0),
        .CNT_W      (CNT_W)
    ) dut (
        .CLK      (clk),
        .RST      (rst),
        .FLUSH    (flush),
        .IN_V     (in_v),
        .IN_DATA  (in_data),
        .IN_RDY   (in_rdy),
        .OUT_V    (out_v),
        .OUT_DATA (out_data),
        .OUT_RDY  (out_rdy),
`ifdef PIPE_SKID_STALL_CNT_EN
        .STALL_CNT(stall_cnt),
`endif
        .OCC      (occ)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; flush = 1'b0; in_v = 1'b0; in_data = '0; out_rdy = 1'b0;
        step();
        rst = 1'b0;
        step();
    endtask

    task automatic test_reset();
        do_reset();
        n_checks++; if (out_v !== 1'b0) begin n_fail++; $display("FAIL reset_out_v got %0b want 0", out_v); end
        n_checks++; if (in_rdy !== 1'b1) begin n_fail++; $display("FAIL reset_in_rdy got %0b want 1", in_rdy); end
        n_checks++; if (occ !== 2'd0) begin n_fail++; $display("FAIL reset_occ got %0d want 0", occ); end
        n_checks++; if (out_data !== 32'h0) begin n_fail++; $display("FAIL reset_out_data got %h want 0", out_data); end
    endtask

    task automatic test_single();
        in_v = 1'b1; in_data = 32'hA5A5_0001; out_rdy = 1'b1;
        step();
        in_v = 1'b0;
        n_checks++; if (out_v !== 1'b1) begin n_fail++; $display("FAIL single_out_v got %0b want 1", out_v); end
        n_checks++; if (out_data !== 32'hA5A5_0001) begin n_fail++; $display("FAIL single_data got %h want a5a50001", out_data); end
        n_checks++; if (occ !== 2'd1) begin n_fail++; $display("FAIL single_occ got %0d want 1", occ); end
        n_checks++; if (in_rdy !== 1'b1) begin n_fail++; $display("FAIL single_in_rdy got %0b want 1", in_rdy); end
        step();
        n_checks++; if (out_v !== 1'b0 || occ !== 2'd0) begin n_fail++; $display("FAIL single_drain got v=%0b occ=%0d want v=0 occ=0", out_v, occ); end
        n_checks++; if (out_data !== 32'hA5A5_0001) begin n_fail++; $display("FAIL single_stale got %h want a5a50001", out_data); end
    endtask

    task automatic test_backpressure();
        in_v = 1'b1; in_data = 32'h1; out_rdy = 1'b1;
        step();
        out_rdy = 1'b0; in_data = 32'h2;
        step();
        n_checks++; if (occ !== 2'd2 || in_rdy !== 1'b0) begin n_fail++; $display("FAIL bp_full got occ=%0d rdy=%0b want occ=2 rdy=0", occ, in_rdy); end
        n_checks++; if (out_data !== 32'h1) begin n_fail++; $display("FAIL bp_head got %h want 1", out_data); end
        in_data = 32'h3;
        step();
        n_checks++; if (occ !== 2'd2 || out_data !== 32'h1 || out_v !== 1'b1) begin n_fail++; $display("FAIL bp_hold got occ=%0d data=%h v=%0b want occ=2 data=1 v=1", occ, out_data, out_v); end
        out_rdy = 1'b1;
        step();
        n_checks++; if (out_data !== 32'h2 || occ !== 2'd1 || in_rdy !== 1'b1) begin n_fail++; $display("FAIL bp_rel1 got data=%h occ=%0d rdy=%0b want data=2 occ=1 rdy=1", out_data, occ, in_rdy); end
        step();
        n_checks++; if (out_data !== 32'h3 || occ !== 2'd1) begin n_fail++; $display("FAIL bp_rel2 got data=%h occ=%0d want data=3 occ=1", out_data, occ); end
        in_data = 32'h4;
        step();
        n_checks++; if (out_data !== 32'h4 || out_v !== 1'b1) begin n_fail++; $display("FAIL bp_rel3 got data=%h v=%0b want data=4 v=1", out_data, out_v); end
        in_v = 1'b0;
        step();
        n_checks++; if (out_v !== 1'b0 || occ !== 2'd0) begin n_fail++; $display("FAIL bp_empty got v=%0b occ=%0d want 0 0", out_v, occ); end
    endtask

    task automatic test_back_to_back();
        out_rdy = 1'b1; in_v = 1'b1;
        for (int i = 0; i < 4; i++) begin
            in_data = 32'hC000_0010 + 32'(i);
            step();
            n_checks++;
            if (out_data !== 32'hC000_0010 + 32'(i) || occ !== 2'd1 || in_rdy !== 1'b1) begin
                n_fail++;
                $display("FAIL b2b_%0d got data=%h occ=%0d rdy=%0b want data=%h occ=1 rdy=1",
                         i, out_data, occ, in_rdy, 32'hC000_0010 + 32'(i));
            end
        end
        in_v = 1'b0;
        step();
    endtask

    task automatic test_flush();
        out_rdy = 1'b0; in_v = 1'b1; in_data = 32'h11;
        step();
        in_data = 32'h22;
        step();
        n_checks++; if (occ !== 2'd2) begin n_fail++; $display("FAIL flush_pre_occ got %0d want 2", occ); end
        flush = 1'b1; in_data = 32'h99;
        step();
        flush = 1'b0; in_v = 1'b0;
        n_checks++; if (out_v !== 1'b0 || occ !== 2'd0 || in_rdy !== 1'b1) begin n_fail++; $display("FAIL flush_full got v=%0b occ=%0d rdy=%0b want 0 0 1", out_v, occ, in_rdy); end
        n_checks++; if (out_data !== 32'h11) begin n_fail++; $display("FAIL flush_data got %h want 11", out_data); end
        // Flush while in ONE with a live in_fire: input must be dropped.
        in_v = 1'b1; in_data = 32'h55;
        step();
        flush = 1'b1; in_data = 32'h77;
        step();
        flush = 1'b0; in_v = 1'b0;
        n_checks++; if (out_v !== 1'b0 || occ !== 2'd0) begin n_fail++; $display("FAIL flush_one got v=%0b occ=%0d want 0 0", out_v, occ); end
        n_checks++; if (out_data !== 32'h55) begin n_fail++; $display("FAIL flush_one_data got %h want 55", out_data); end
        step();
        n_checks++; if (out_v !== 1'b0 || out_data !== 32'h55) begin n_fail++; $display("FAIL flush_after got v=%0b data=%h want 0 55", out_v, out_data); end
    endtask

    task automatic test_async_reset();
        out_rdy = 1'b0; in_v = 1'b1; in_data = 32'hAB;
        step();
        in_data = 32'hCD;
        step();
        in_v = 1'b0;
        n_checks++; if (occ !== 2'd2) begin n_fail++; $display("FAIL arst_pre_occ got %0d want 2", occ); end
        #3 rst = 1'b1;
        #2 rst = 1'b0;
        #1;
        n_checks++; if (out_v !== 1'b0 || in_rdy !== 1'b1) begin n_fail++; $display("FAIL arst_hs got v=%0b rdy=%0b want 0 1", out_v, in_rdy); end
        n_checks++; if (occ !== 2'd0) begin n_fail++; $display("FAIL arst_occ got %0d want 0", occ); end
        n_checks++; if (out_data !== 32'h0) begin n_fail++; $display("FAIL arst_data got %h want 0", out_data); end
        step();
        n_checks++; if (out_v !== 1'b0 || occ !== 2'd0) begin n_fail++; $display("FAIL arst_after got v=%0b occ=%0d want 0 0", out_v, occ); end
    endtask

`ifdef PIPE_SKID_STALL_CNT_EN
    task automatic test_stall_cnt();
        logic [CNT_W-1:0] exp_cnt [5];
        exp_cnt[0] = 2'd1; exp_cnt[1] = 2'd2; exp_cnt[2] = 2'd3; exp_cnt[3] = 2'd3; exp_cnt[4] = 2'd3;
        do_reset();
        n_checks++; if (stall_cnt !== 2'd0) begin n_fail++; $display("FAIL stall_init got %0d want 0", stall_cnt); end
        out_rdy = 1'b0; in_v = 1'b1; in_data = 32'h5;
        step();
        in_v = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step();
            n_checks++;
            if (stall_cnt !== exp_cnt[i]) begin n_fail++; $display("FAIL stall_cnt_%0d got %0d want %0d", i, stall_cnt, exp_cnt[i]); end
        end
        flush = 1'b1;
        step();
        flush = 1'b0;
        n_checks++; if (stall_cnt !== 2'd3) begin n_fail++; $display("FAIL stall_flush got %0d want 3", stall_cnt); end
        #2 rst = 1'b1;
        #1 rst = 1'b0;
        #1;
        n_checks++; if (stall_cnt !== 2'd0) begin n_fail++; $display("FAIL stall_rst got %0d want 0", stall_cnt); end
    endtask
`endif

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst = 1'b1; flush = 1'b0; in_v = 1'b0; in_data = '0; out_rdy = 1'b0;
        test_reset();
        test_single();
        test_backpressure();
        test_back_to_back();
        test_flush();
        test_async_reset();
`ifdef PIPE_SKID_STALL_CNT_EN
        test_stall_cnt();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
